mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (IF) and data (DM) share one memory port.
// Optional macro MEM_ARB_STARVE_EN enables the IF starvation guard; otherwise DM has strict priority.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          stall_if,
    output logic          stall_dm
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GNT_IF = 2'd1;
    localparam logic [1:0] GNT_DM = 2'd2;

    logic [1:0] state;
    logic       armed;
    logic       guard;
    logic       grant_if;
    logic       grant_dm;

`ifdef MEM_ARB_STARVE_EN
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
    logic [3:0] wait_cnt;

    assign guard = if_req && (wait_cnt == WAIT_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_if)
                wait_cnt <= '0;
            else if (grant_dm && if_req && wait_cnt != WAIT_LIM)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    assign guard = 1'b0;
`endif

    // armed holds off arbitration for the first edge after reset release
    assign grant_dm = armed && dm_req && !guard;
    assign grant_if = armed && if_req && (!dm_req || guard);

    assign stall_if = if_req & ~if_ready;
    assign stall_dm = dm_req & ~dm_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            armed    <= 1'b0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            armed    <= 1'b1;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state   <= GNT_DM;
                        m_req   <= 1'b1;
                        m_we    <= dm_we;
                        m_addr  <= dm_addr;
                        m_wdata <= dm_wdata;
                    end else if (grant_if) begin
                        state  <= GNT_IF;
                        m_req  <= 1'b1;
                        m_we   <= 1'b0;
                        m_addr <= if_addr;
                    end
                end
                GNT_IF: begin
                    if (m_ack) begin
                        state    <= IDLE;
                        m_req    <= 1'b0;
                        if_ready <= 1'b1;
                        if_rdata <= m_rdata;
                    end
                end
                GNT_DM: begin
                    if (m_ack) begin
                        state    <= IDLE;
                        m_req    <= 1'b0;
                        dm_ready <= 1'b1;
                        if (!m_we)
                            dm_rdata <= m_rdata;
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
